// File: rtl/result_uart_tx.sv
// UART 8N1 transmitter that serialises an N-bit result word, most significant byte
// first, LSB first within each byte; busy while sending, one-cycle done at the end.
module result_uart_tx #(
  parameter int clk_freq       = 50000000,
  parameter int uart_baud_rate = 57600,
  parameter int N              = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic [N-1:0] i_data,
  output logic         o_txd,
  output logic         o_busy,
  output logic         o_done
);

  localparam int DIV = clk_freq / uart_baud_rate;
  localparam int NB  = N / 8;
  localparam int BCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BYW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t         state_q, state_d;
  logic [BCW-1:0] bc_q, bc_d;
  logic [2:0]     bi_q, bi_d;
  logic [BYW-1:0] by_q, by_d;
  logic [N-1:0]   shreg_q, shreg_d;
  logic [7:0]     txbyte_q, txbyte_d;
  logic           txd_q, txd_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           bc_last;
  logic           accept;

  assign bc_last = (bc_q == BCW'(DIV - 1));

  // NOTE: every signal assigned below gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    bc_d     = bc_q;
    bi_d     = bi_q;
    by_d     = by_q;
    shreg_d  = shreg_q;
    txbyte_d = txbyte_q;
    txd_d    = txd_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    accept   = 1'b0;

    unique case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (i_start) accept = 1'b1;
      end

      START: begin
        bc_d = bc_last ? '0 : bc_q + 1'b1;
        if (bc_last) begin
          // The word is consumed from the top; shifting keeps the next byte at the MSB end.
          txbyte_d = shreg_q[N-1 -: 8];
          shreg_d  = shreg_q << 8;
          bi_d     = 3'd0;
          txd_d    = shreg_q[N-8];
          state_d  = DATA;
        end
      end

      DATA: begin
        bc_d = bc_last ? '0 : bc_q + 1'b1;
        if (bc_last) begin
          if (bi_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = STOP;
          end else begin
            bi_d  = bi_q + 3'd1;
            txd_d = txbyte_q[bi_q + 3'd1];
          end
        end
      end

      STOP: begin
        bc_d = bc_last ? '0 : bc_q + 1'b1;
        if (bc_last) begin
          if (by_q != BYW'(NB - 1)) begin
            by_d    = by_q + 1'b1;
            txd_d   = 1'b0;
            state_d = START;
          end else begin
            done_d = 1'b1;
            // A pending request chains straight into the next frame with no idle cell.
            if (i_start) begin
              accept = 1'b1;
            end else begin
              busy_d  = 1'b0;
              txd_d   = 1'b1;
              state_d = IDLE;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if (accept) begin
      shreg_d = i_data;
      by_d    = '0;
      bc_d    = '0;
      bi_d    = 3'd0;
      txd_d   = 1'b0;
      busy_d  = 1'b1;
      state_d = START;
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      bc_q     <= '0;
      bi_q     <= 3'd0;
      by_q     <= '0;
      shreg_q  <= '0;
      txbyte_q <= 8'd0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bc_q     <= bc_d;
      bi_q     <= bi_d;
      by_q     <= by_d;
      shreg_q  <= shreg_d;
      txbyte_q <= txbyte_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign o_txd  = txd_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// Directed bench for result_uart_tx: fast instance (16 cycles per bit) for framing
// and corner cases, default instance for the 868-cycle bit cell.
module tb_result_uart_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_start = 1'b0;
  logic [15:0] i_data = 16'h0000;
  logic        o_txd, o_busy, o_done;

  logic        d_start = 1'b0;
  logic [15:0] d_data = 16'h0000;
  logic        d_txd, d_busy, d_done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  result_uart_tx #(.clk_freq(16), .uart_baud_rate(1), .N(16)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_data(i_data),
    .o_txd(o_txd), .o_busy(o_busy), .o_done(o_done)
  );

  result_uart_tx dut_def (
    .clk(clk), .rst(rst), .i_start(d_start), .i_data(d_data),
    .o_txd(d_txd), .o_busy(d_busy), .o_done(d_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [15:0] data;
    logic [0:19] line;     // expected line level per bit cell, in time order
    int          poke_at;  // cycle at which a stray start pulse is injected, -1 for none
  } vec_t;

  // Drives one start strobe and samples the frame on falling edges; cycle 0 is the
  // cycle right after the accepting edge.
  task automatic run_frame(input string name, input logic [15:0] data,
                           input logic [0:19] line, input int poke_at);
    int done_cnt = 0;
    int done_at  = -1;
    int busy_cnt = 0;
    @(negedge clk);
    i_start = 1'b1;
    i_data  = data;
    for (int c = 0; c < 340; c++) begin
      @(negedge clk);
      if (c < 320 && (c % 16) == 8)
        check($sformatf("%s cell%0d", name, c / 16), o_txd, line[c / 16]);
      if (o_busy) busy_cnt++;
      if (o_done) begin
        done_cnt++;
        done_at = c;
      end
      if (c == 0) begin
        i_start = 1'b0;
        i_data  = 16'hDEAD;
      end
      if (c == poke_at) begin
        i_start = 1'b1;
        i_data  = 16'h1234;
      end
      if (c == poke_at + 1) i_start = 1'b0;
    end
    check({name, " done_count"}, done_cnt, 1);
    check({name, " done_cycle"}, done_at, 320);
    check({name, " busy_cycles"}, busy_cnt, 320);
    check({name, " idle_txd"}, o_txd, 1'b1);
  endtask

  vec_t vecs[5];

  localparam logic [0:19] LINE_A55A = 20'b0_10100101_1_0_01011010_1;
  localparam logic [0:19] LINE_00FF = 20'b0_00000000_1_0_11111111_1;
  localparam logic [0:19] LINE_FF00 = 20'b0_11111111_1_0_00000000_1;
  localparam logic [0:19] LINE_1234 = 20'b0_01001000_1_0_00101100_1;
  localparam logic [0:19] LINE_0001 = 20'b0_00000000_1_0_10000000_1;

  initial begin
    vecs[0] = '{"A55A",      16'hA55A, LINE_A55A, -1};
    vecs[1] = '{"00FF",      16'h00FF, LINE_00FF, -1};
    vecs[2] = '{"1234",      16'h1234, LINE_1234, -1};
    vecs[3] = '{"0001",      16'h0001, LINE_0001, -1};
    vecs[4] = '{"busy_poke", 16'hA55A, LINE_A55A, 100};

    // Power-on reset
    #2 rst = 1'b1;
    #1;
    check("por txd", o_txd, 1'b1);
    check("por busy", o_busy, 1'b0);
    check("por done", o_done, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle txd", o_txd, 1'b1);
    check("idle busy", o_busy, 1'b0);

    // Main function, including the ignored mid-frame start pulse
    for (int v = 0; v < 5; v++)
      run_frame(vecs[v].name, vecs[v].data, vecs[v].line, vecs[v].poke_at);

    // Async reset mid-cycle during the start bit
    @(negedge clk);
    i_start = 1'b1;
    i_data  = 16'hA55A;
    @(negedge clk);
    i_start = 1'b0;
    repeat (8) @(negedge clk);
    check("t1 pre txd", o_txd, 1'b0);
    check("t1 pre busy", o_busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t1 txd", o_txd, 1'b1);
    check("t1 busy", o_busy, 1'b0);
    check("t1 done", o_done, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Reset during data bit 3 of byte 0, then a clean frame
    @(negedge clk);
    i_start = 1'b1;
    i_data  = 16'hA55A;
    @(negedge clk);
    i_start = 1'b0;
    repeat (70) @(negedge clk);
    check("t5 pre txd", o_txd, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("t5 txd", o_txd, 1'b1);
    check("t5 busy", o_busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int bad = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (o_txd !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0) bad++;
      end
      check("t5 stays idle", bad, 0);
    end
    run_frame("t5 0001", 16'h0001, LINE_0001, -1);

    // Back-to-back with i_start held high
    begin
      int done_cnt = 0;
      int first_done = -1;
      int second_done = -1;
      @(negedge clk);
      i_start = 1'b1;
      i_data  = 16'h00FF;
      for (int c = 0; c < 700; c++) begin
        @(negedge clk);
        if (c < 320 && (c % 16) == 8)
          check($sformatf("b2b f1 cell%0d", c / 16), o_txd, LINE_00FF[c / 16]);
        if (c >= 320 && c < 640 && (c % 16) == 8)
          check($sformatf("b2b f2 cell%0d", (c - 320) / 16), o_txd, LINE_FF00[(c - 320) / 16]);
        if (c == 320) begin
          check("b2b chain busy", o_busy, 1'b1);
          check("b2b chain txd", o_txd, 1'b0);
        end
        if (c == 640) check("b2b end busy", o_busy, 1'b0);
        if (o_done) begin
          done_cnt++;
          if (first_done < 0) first_done = c;
          else second_done = c;
        end
        if (c == 0) i_data = 16'hFF00;
        if (c == 330) i_start = 1'b0;
      end
      check("b2b done_count", done_cnt, 2);
      check("b2b first_done", first_done, 320);
      check("b2b done_spacing", second_done - first_done, 320);
    end

    // Default parameters: 868 cycles per bit cell
    begin
      int runs[3];
      int nrun = 0;
      int len = 0;
      int done_at = -1;
      logic prev;
      @(negedge clk);
      d_start = 1'b1;
      d_data  = 16'h5555;
      @(negedge clk);
      d_start = 1'b0;
      prev = d_txd;
      len  = 1;
      check("def start txd", d_txd, 1'b0);
      for (int c = 1; c < 18000 && done_at < 0; c++) begin
        @(negedge clk);
        if (d_done) done_at = c;
        if (d_txd === prev) begin
          len++;
        end else begin
          if (nrun < 3) runs[nrun] = len;
          nrun++;
          prev = d_txd;
          len  = 1;
        end
      end
      check("def run count", (nrun >= 3) ? 1 : 0, 1);
      for (int r = 0; r < 3; r++)
        check($sformatf("def cell%0d len", r), (nrun > r) ? runs[r] : -1, 868);
      check("def done cycle", done_at, 17360);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
